// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the even/odd byte-bank instruction memory between the fetch and
// data/debug requesters, reading each 32-bit word as two 16-bit beats. Define ARB_RR_EN for round-robin.
module imem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr_low,
  output logic [31:0] mem_addr_high,
  input  logic [7:0]  mem_ins_low,
  input  logic [7:0]  mem_ins_high,
  output logic        busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_owner_d;
  logic [31:0] r_addr;
  logic [15:0] r_word_lo;
  logic [31:0] r_mem_lo;
  logic [31:0] r_mem_hi;
  logic [31:0] r_f_rdata;
  logic [31:0] r_d_rdata;
  logic        r_f_rvalid;
  logic        r_d_rvalid;

  logic        w_idle;
  logic        w_pick_d;
  logic        w_f_gnt;
  logic        w_d_gnt;
  logic        w_grant;
  logic        w_cnt_done;
  logic [31:0] w_base;
  logic [15:0] w_beat;

`ifdef ARB_RR_EN
  logic r_last_d;
  // The port granted last loses a tie; the reset value makes fetch win the first tie.
  assign w_pick_d = d_req && (!f_req || !r_last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b1;
    end else if (w_grant) begin
      r_last_d <= w_d_gnt;
    end
  end
`else
  assign w_pick_d = d_req && !f_req;
`endif

  // Grants are gated by rst so they read 0 for the whole reset pulse.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_f_gnt    = w_idle && f_req && !w_pick_d;
  assign w_d_gnt    = w_idle && w_pick_d;
  assign w_grant    = w_f_gnt || w_d_gnt;
  assign w_base     = (w_pick_d ? d_addr : f_addr) & 32'hFFFF_FFFC;
  assign w_cnt_done = (r_cnt == CNT_LAST);
  assign w_beat     = {mem_ins_high, mem_ins_low};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_owner_d  <= 1'b0;
      r_mem_lo   <= 32'd0;
      r_mem_hi   <= 32'd1;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner_d <= w_d_gnt;
            r_mem_lo  <= w_base;
            r_mem_hi  <= w_base + 32'd1;
            r_cnt     <= 3'd0;
            r_state   <= S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (w_cnt_done) begin
            r_mem_lo <= r_addr + 32'd2;
            r_mem_hi <= r_addr + 32'd3;
            r_cnt    <= 3'd0;
            r_state  <= S_BEAT1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_BEAT1: begin
          if (w_cnt_done) begin
            if (r_owner_d) begin
              r_d_rdata  <= {w_beat, r_word_lo};
              r_d_rvalid <= 1'b1;
            end else begin
              r_f_rdata  <= {w_beat, r_word_lo};
              r_f_rvalid <= 1'b1;
            end
            r_cnt   <= 3'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word address and low half are pure datapath and need no reset.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr <= w_base;
    end
    if ((r_state == S_BEAT0) && w_cnt_done) begin
      r_word_lo <= w_beat;
    end
  end

  assign f_gnt         = w_f_gnt;
  assign d_gnt         = w_d_gnt;
  assign f_rvalid      = r_f_rvalid;
  assign d_rvalid      = r_d_rvalid;
  assign f_rdata       = r_f_rdata;
  assign d_rdata       = r_d_rdata;
  assign mem_addr_low  = r_mem_lo;
  assign mem_addr_high = r_mem_hi;
  assign busy          = (r_state != S_IDLE);

endmodule
